id_stage_param: RTL and testbench

// - Parametrised instruction-decode stage for the 5-stage MIPS pipeline.
// - Contains the register file, immediate extension, branch-target adder, load-use hazard

---
 rtl/id_pkg.sv | 126 ++++++++++++
 rtl/id_regfile.sv | 57 +++++
 rtl/id_stage_param.sv | 168 ++++++++++++++++
 tb/tb_id_stage_param.sv | 341 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/id_pkg.sv
// Shared decode definitions for the ID stage: control-word layout, opcode/funct
// encodings, the main control decoder and the rt-as-source predicate.
package id_pkg;

    typedef struct packed {
        logic       reg_dst;
        logic       alu_src;
        logic       mem_to_reg;
        logic       reg_write;
        logic       mem_read;
        logic       mem_write;
        logic       branch;
        logic       bne;
        logic       jump;
        logic [1:0] alu_op;
        logic [2:0] trunk_mode;
        logic [1:0] jdes_sel;
    } ctrl_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_XORI  = 6'h0E;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LB    = 6'h20;
    localparam logic [5:0] OP_LH    = 6'h21;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_LBU   = 6'h24;
    localparam logic [5:0] OP_LHU   = 6'h25;
    localparam logic [5:0] OP_SB    = 6'h28;
    localparam logic [5:0] OP_SH    = 6'h29;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_JR    = 6'h08;

    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_RTYPE = 2'b10;
    localparam logic [1:0] ALU_IMM   = 2'b11;

    localparam logic [2:0] TRUNK_WORD  = 3'd0;
    localparam logic [2:0] TRUNK_BYTE  = 3'd1;
    localparam logic [2:0] TRUNK_HALF  = 3'd2;
    localparam logic [2:0] TRUNK_BYTEU = 3'd3;
    localparam logic [2:0] TRUNK_HALFU = 3'd4;

    localparam logic [1:0] JDES_PC1    = 2'd0;
    localparam logic [1:0] JDES_BRANCH = 2'd1;
    localparam logic [1:0] JDES_JUMP   = 2'd2;
    localparam logic [1:0] JDES_REG    = 2'd3;

    function automatic ctrl_t decode_ctrl(input logic [5:0] opcode, input logic [5:0] funct);
        ctrl_t c;
        c = '0;
        case (opcode)
            OP_RTYPE: begin
                if (funct == FN_JR) begin
                    c.jump     = 1'b1;
                    c.jdes_sel = JDES_REG;
                end else begin
                    c.reg_dst   = 1'b1;
                    c.reg_write = 1'b1;
                    c.alu_op    = ALU_RTYPE;
                end
            end
            OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU: begin
                c.alu_src    = 1'b1;
                c.mem_to_reg = 1'b1;
                c.reg_write  = 1'b1;
                c.mem_read   = 1'b1;
                c.alu_op     = ALU_ADD;
                case (opcode)
                    OP_LB:   c.trunk_mode = TRUNK_BYTE;
                    OP_LH:   c.trunk_mode = TRUNK_HALF;
                    OP_LBU:  c.trunk_mode = TRUNK_BYTEU;
                    OP_LHU:  c.trunk_mode = TRUNK_HALFU;
                    default: c.trunk_mode = TRUNK_WORD;
                endcase
            end
            OP_SB, OP_SH, OP_SW: begin
                c.alu_src   = 1'b1;
                c.mem_write = 1'b1;
                c.alu_op    = ALU_ADD;
                case (opcode)
                    OP_SB:   c.trunk_mode = TRUNK_BYTE;
                    OP_SH:   c.trunk_mode = TRUNK_HALF;
                    default: c.trunk_mode = TRUNK_WORD;
                endcase
            end
            OP_BEQ, OP_BNE: begin
                c.branch   = 1'b1;
                c.bne      = (opcode == OP_BNE);
                c.alu_op   = ALU_SUB;
                c.jdes_sel = JDES_BRANCH;
            end
            OP_J, OP_JAL: begin
                c.jump      = 1'b1;
                c.reg_write = (opcode == OP_JAL);
                c.jdes_sel  = JDES_JUMP;
            end
            OP_ADDI, OP_ADDIU, OP_SLTI, OP_ANDI, OP_ORI, OP_XORI, OP_LUI: begin
                c.alu_src   = 1'b1;
                c.reg_write = 1'b1;
                c.alu_op    = ALU_IMM;
            end
            default: c = '0;
        endcase
        return c;
    endfunction

    // True when the rt field is a source operand rather than a destination.
    function automatic logic uses_rt(input logic [5:0] opcode);
        case (opcode)
            OP_RTYPE, OP_BEQ, OP_BNE, OP_SB, OP_SH, OP_SW: return 1'b1;
            default:                                       return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/id_regfile.sv
// Register file: NREGS x DATA_W, two read ports, one write port, one debug read port.
// Define ID_WB_BYPASS_EN to forward same-cycle write data onto the two read ports.
module id_regfile #(
    parameter int DATA_W = 32,
    parameter int NREGS  = 32,
    parameter int AREG_W = 5
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [AREG_W-1:0] ra_addr,
    input  logic [AREG_W-1:0] rb_addr,
    output logic [DATA_W-1:0] ra_data,
    output logic [DATA_W-1:0] rb_data,
    input  logic              we,
    input  logic [AREG_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [AREG_W-1:0] dbg_addr,
    output logic [DATA_W-1:0] dbg_data
);

    logic [NREGS-1:0][DATA_W-1:0] mem_q;
    logic [NREGS-1:0][DATA_W-1:0] mem_d;
    logic                         wr_hit;

    assign wr_hit = we && (waddr != '0);

    // NOTE: every always_comb output gets a full default first so no path leaves it unassigned (no latch).
    always_comb begin
        mem_d = mem_q;
        if (wr_hit) begin
            mem_d[waddr] = wdata;
        end
    end

    // NOTE: sequential state uses non-blocking assignment so all flops update from pre-edge values.
    // NOTE: the array is reset in full because software relies on every register reading 0 after reset;
    //       this keeps it in flops rather than a RAM macro.
    always_ff @(posedge clock) begin
        if (reset) begin
            mem_q <= '0;
        end else begin
            mem_q <= mem_d;
        end
    end

    always_comb begin
        ra_data = (ra_addr == '0) ? '0 : mem_q[ra_addr];
        rb_data = (rb_addr == '0) ? '0 : mem_q[rb_addr];
`ifdef ID_WB_BYPASS_EN
        if (wr_hit && (waddr == ra_addr)) ra_data = wdata;
        if (wr_hit && (waddr == rb_addr)) rb_data = wdata;
`endif
    end

    assign dbg_data = mem_q[dbg_addr];

endmodule

// File: rtl/id_stage_param.sv
// MIPS decode stage: register file, immediate/branch-target, load-use stall and ID/EX register.
// ID_WB_BYPASS_EN selects write-through from WB into the operand read ports.
module id_stage_param #(
    parameter int DATA_W = 32,
    parameter int PC_W   = 11,
    parameter int NREGS  = 32,
    parameter int AREG_W = 5,
    parameter int CTRL_W = 16
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              instr_valid,
    input  logic [31:0]       instruction,
    input  logic [PC_W-1:0]   pc_in,
    input  logic              flush,
    input  logic              wb_we,
    input  logic [AREG_W-1:0] wb_addr,
    input  logic [DATA_W-1:0] wb_data,
    output logic              stall,
    output logic              ex_valid,
    output logic [DATA_W-1:0] data_a,
    output logic [DATA_W-1:0] data_b,
    output logic [DATA_W-1:0] imm,
    output logic [PC_W-1:0]   branch_dest,
    output logic [AREG_W-1:0] rs,
    output logic [AREG_W-1:0] rt,
    output logic [AREG_W-1:0] rd,
    output logic [4:0]        sa,
    output logic [5:0]        op_code,
    output logic [PC_W-1:0]   pc_out,
    output logic [CTRL_W-1:0] ctrl,
    input  logic [AREG_W-1:0] dbg_addr,
    output logic [DATA_W-1:0] dbg_data
);

    import id_pkg::*;

    logic [5:0]        id_op;
    logic [5:0]        id_funct;
    logic [AREG_W-1:0] id_rs;
    logic [AREG_W-1:0] id_rt;
    logic [AREG_W-1:0] id_rd;
    logic [4:0]        id_sa;
    logic [DATA_W-1:0] id_imm;
    logic [PC_W-1:0]   id_bdest;
    ctrl_t             id_ctrl;
    logic [DATA_W-1:0] rf_a;
    logic [DATA_W-1:0] rf_b;

    assign id_op    = instruction[31:26];
    assign id_funct = instruction[5:0];
    assign id_rs    = AREG_W'(instruction[25:21]);
    assign id_rt    = AREG_W'(instruction[20:16]);
    assign id_rd    = AREG_W'(instruction[15:11]);
    assign id_sa    = instruction[10:6];
    assign id_imm   = {{(DATA_W-16){instruction[15]}}, instruction[15:0]};
    // Word-addressed PC: the offset is added as-is and wraps at PC_W bits.
    assign id_bdest = pc_in + id_imm[PC_W-1:0];
    assign id_ctrl  = decode_ctrl(id_op, id_funct);

    id_regfile #(
        .DATA_W (DATA_W),
        .NREGS  (NREGS),
        .AREG_W (AREG_W)
    ) u_regfile (
        .clock    (clock),
        .reset    (reset),
        .ra_addr  (id_rs),
        .rb_addr  (id_rt),
        .ra_data  (rf_a),
        .rb_data  (rf_b),
        .we       (wb_we),
        .waddr    (wb_addr),
        .wdata    (wb_data),
        .dbg_addr (dbg_addr),
        .dbg_data (dbg_data)
    );

    logic              ex_valid_q,    ex_valid_d;
    ctrl_t             ctrl_q,        ctrl_d;
    logic [DATA_W-1:0] data_a_q,      data_a_d;
    logic [DATA_W-1:0] data_b_q,      data_b_d;
    logic [DATA_W-1:0] imm_q,         imm_d;
    logic [PC_W-1:0]   bdest_q,       bdest_d;
    logic [PC_W-1:0]   pc_q,          pc_d;
    logic [AREG_W-1:0] rs_q,          rs_d;
    logic [AREG_W-1:0] rt_q,          rt_d;
    logic [AREG_W-1:0] rd_q,          rd_d;
    logic [4:0]        sa_q,          sa_d;
    logic [5:0]        op_q,          op_d;

    // A load in EX whose destination feeds this instruction cannot be forwarded in time.
    assign stall = instr_valid && ex_valid_q && ctrl_q.mem_read && (rt_q != '0) &&
                   ((rt_q == id_rs) || ((rt_q == id_rt) && uses_rt(id_op)));

    always_comb begin
        ex_valid_d = 1'b0;
        ctrl_d     = '0;
        data_a_d   = '0;
        data_b_d   = '0;
        imm_d      = '0;
        bdest_d    = '0;
        pc_d       = '0;
        rs_d       = '0;
        rt_d       = '0;
        rd_d       = '0;
        sa_d       = '0;
        op_d       = '0;
        if (!flush && !stall) begin
            ex_valid_d = instr_valid;
            ctrl_d     = instr_valid ? id_ctrl : '0;
            data_a_d   = rf_a;
            data_b_d   = rf_b;
            imm_d      = id_imm;
            bdest_d    = id_bdest;
            pc_d       = pc_in;
            rs_d       = id_rs;
            rt_d       = id_rt;
            rd_d       = id_rd;
            sa_d       = id_sa;
            op_d       = id_op;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            ex_valid_q <= 1'b0;
            ctrl_q     <= '0;
            data_a_q   <= '0;
            data_b_q   <= '0;
            imm_q      <= '0;
            bdest_q    <= '0;
            pc_q       <= '0;
            rs_q       <= '0;
            rt_q       <= '0;
            rd_q       <= '0;
            sa_q       <= '0;
            op_q       <= '0;
        end else begin
            ex_valid_q <= ex_valid_d;
            ctrl_q     <= ctrl_d;
            data_a_q   <= data_a_d;
            data_b_q   <= data_b_d;
            imm_q      <= imm_d;
            bdest_q    <= bdest_d;
            pc_q       <= pc_d;
            rs_q       <= rs_d;
            rt_q       <= rt_d;
            rd_q       <= rd_d;
            sa_q       <= sa_d;
            op_q       <= op_d;
        end
    end

    assign ex_valid    = ex_valid_q;
    assign ctrl        = CTRL_W'(ctrl_q);
    assign data_a      = data_a_q;
    assign data_b      = data_b_q;
    assign imm         = imm_q;
    assign branch_dest = bdest_q;
    assign pc_out      = pc_q;
    assign rs          = rs_q;
    assign rt          = rt_q;
    assign rd          = rd_q;
    assign sa          = sa_q;
    assign op_code     = op_q;

endmodule

// File: tb/tb_id_stage_param.sv
// Directed bench for id_stage_param: expected ID/EX contents are queued at drive time
// and compared one edge later; stall and debug reads are checked combinationally.
module tb_id_stage_param;

    localparam logic [15:0] C_ADD  = 16'h9040;
    localparam logic [15:0] C_LW   = 16'h7800;
    localparam logic [15:0] C_SW   = 16'h4400;
    localparam logic [15:0] C_BEQ  = 16'h0221;
    localparam logic [15:0] C_ADDI = 16'h5060;

    logic        clock;
    logic        reset;
    logic        instr_valid;
    logic [31:0] instruction;
    logic [10:0] pc_in;
    logic        flush;
    logic        wb_we;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic        stall;
    logic        ex_valid;
    logic [31:0] data_a;
    logic [31:0] data_b;
    logic [31:0] imm;
    logic [10:0] branch_dest;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [4:0]  sa;
    logic [5:0]  op_code;
    logic [10:0] pc_out;
    logic [15:0] ctrl;
    logic [4:0]  dbg_addr;
    logic [31:0] dbg_data;

    id_stage_param dut (
        .clock       (clock),
        .reset       (reset),
        .instr_valid (instr_valid),
        .instruction (instruction),
        .pc_in       (pc_in),
        .flush       (flush),
        .wb_we       (wb_we),
        .wb_addr     (wb_addr),
        .wb_data     (wb_data),
        .stall       (stall),
        .ex_valid    (ex_valid),
        .data_a      (data_a),
        .data_b      (data_b),
        .imm         (imm),
        .branch_dest (branch_dest),
        .rs          (rs),
        .rt          (rt),
        .rd          (rd),
        .sa          (sa),
        .op_code     (op_code),
        .pc_out      (pc_out),
        .ctrl        (ctrl),
        .dbg_addr    (dbg_addr),
        .dbg_data    (dbg_data)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct packed {
        logic        ex_valid;
        logic [15:0] ctrl;
        logic [31:0] data_a;
        logic [31:0] data_b;
        logic [31:0] imm;
        logic [10:0] bdest;
        logic [10:0] pc;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic [4:0]  sa;
        logic [5:0]  op;
    } exp_t;

    exp_t        exp_q[$];
    string       tag_q[$];
    logic [31:0] shadow [32];
    int          n_checks = 0;
    int          n_fail   = 0;

    function automatic logic [31:0] r_ins(input int rs_i, input int rt_i, input int rd_i, input logic [5:0] fn);
        return {6'h00, 5'(rs_i), 5'(rt_i), 5'(rd_i), 5'd0, fn};
    endfunction

    function automatic logic [31:0] i_ins(input logic [5:0] op, input int rs_i, input int rt_i, input logic [15:0] im);
        return {op, 5'(rs_i), 5'(rt_i), im};
    endfunction

    function automatic logic [31:0] rd_model(input logic [4:0] a);
        if (a == 5'd0) return 32'd0;
`ifdef ID_WB_BYPASS_EN
        if (wb_we && (wb_addr == a)) return wb_data;
`endif
        return shadow[a];
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
        end
    endtask

    task automatic drive(input string tag, input logic [31:0] ins, input logic [10:0] pc,
                         input logic v, input logic fl, input logic bubble, input logic [15:0] c);
        exp_t e;
        instruction = ins;
        pc_in       = pc;
        instr_valid = v;
        flush       = fl;
        e = '0;
        if (!bubble) begin
            e.ex_valid = v;
            e.ctrl     = v ? c : 16'h0000;
            e.data_a   = rd_model(ins[25:21]);
            e.data_b   = rd_model(ins[20:16]);
            e.imm      = {{16{ins[15]}}, ins[15:0]};
            e.bdest    = pc + e.imm[10:0];
            e.pc       = pc;
            e.rs       = ins[25:21];
            e.rt       = ins[20:16];
            e.rd       = ins[15:11];
            e.sa       = ins[10:6];
            e.op       = ins[31:26];
        end
        exp_q.push_back(e);
        tag_q.push_back(tag);
    endtask

    task automatic step();
        logic        do_wr;
        logic [4:0]  wa;
        logic [31:0] wd;
        logic        rst;
        exp_t        e;
        string       t;
        do_wr = wb_we && (wb_addr != 5'd0);
        wa    = wb_addr;
        wd    = wb_data;
        rst   = reset;
        @(posedge clock);
        #1;
        if (rst) begin
            foreach (shadow[i]) shadow[i] = 32'd0;
        end else if (do_wr) begin
            shadow[wa] = wd;
        end
        if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $error("FAIL scoreboard: observed empty queue expected an entry");
        end else begin
            e = exp_q.pop_front();
            t = tag_q.pop_front();
            check($sformatf("%s.ex_valid", t), 32'(ex_valid),    32'(e.ex_valid));
            check($sformatf("%s.ctrl", t),     32'(ctrl),        32'(e.ctrl));
            check($sformatf("%s.data_a", t),   data_a,           e.data_a);
            check($sformatf("%s.data_b", t),   data_b,           e.data_b);
            check($sformatf("%s.imm", t),      imm,              e.imm);
            check($sformatf("%s.bdest", t),    32'(branch_dest), 32'(e.bdest));
            check($sformatf("%s.pc_out", t),   32'(pc_out),      32'(e.pc));
            check($sformatf("%s.fields", t),   {5'd0, rs, rt, rd, sa, op_code},
                                               {5'd0, e.rs, e.rt, e.rd, e.sa, e.op});
        end
    endtask

    task automatic idle(input string tag);
        drive(tag, 32'd0, 11'd0, 1'b0, 1'b0, 1'b0, 16'h0000);
        step();
    endtask

    task automatic wb_write(input logic [4:0] a, input logic [31:0] d);
        wb_we   = 1'b1;
        wb_addr = a;
        wb_data = d;
        idle("wb_idle");
        wb_we   = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed no summary by 100000ns expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] lw9;
        logic [31:0] add_h;
        logic [31:0] byp;
        foreach (shadow[i]) shadow[i] = 32'd0;
        reset       = 1'b1;
        instr_valid = 1'b0;
        instruction = 32'd0;
        pc_in       = 11'd0;
        flush       = 1'b0;
        wb_we       = 1'b0;
        wb_addr     = 5'd0;
        wb_data     = 32'd0;
        dbg_addr    = 5'd0;
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;

        check("reset.ex_valid", 32'(ex_valid), 32'd0);
        check("reset.ctrl",     32'(ctrl),     32'd0);
        check("reset.pc_out",   32'(pc_out),   32'd0);
        for (int i = 0; i < 32; i++) begin
            dbg_addr = 5'(i);
            #1;
            check($sformatf("reset.dbg_r%0d", i), dbg_data, 32'd0);
        end
        @(posedge clock);
        #1;

        // Register 0 ignores writes; register 5 takes effect only after the edge.
        dbg_addr = 5'd0;
        wb_write(5'd0, 32'h0000DEAD);
        #1;
        check("dbg_r0_after_write", dbg_data, 32'd0);
        dbg_addr = 5'd5;
        wb_we = 1'b1; wb_addr = 5'd5; wb_data = 32'h0000DEAD;
        drive("wb_r5_idle", 32'd0, 11'd0, 1'b0, 1'b0, 1'b0, 16'h0000);
        #1;
        check("dbg_r5_before_edge", dbg_data, 32'd0);
        step();
        wb_we = 1'b0;
        #1;
        check("dbg_r5_after_edge", dbg_data, 32'h0000DEAD);

        wb_write(5'd9,  32'h00000100);
        wb_write(5'd11, 32'h00000022);
        wb_write(5'd3,  32'h00000011);
        wb_write(5'd16, 32'h00004000);

        // Load-use on rs: one bubble, then the add proceeds.
        lw9   = i_ins(6'h23, 16, 9, 16'h0004);
        add_h = r_ins(9, 11, 10, 6'h20);
        drive("lw_t1", lw9, 11'h020, 1'b1, 1'b0, 1'b0, C_LW);
        #1;
        check("no_stall_before_lw", 32'(stall), 32'd0);
        step();
        drive("stall_bubble", add_h, 11'h021, 1'b1, 1'b0, 1'b1, 16'h0000);
        #1;
        check("stall_on_load_use", 32'(stall), 32'd1);
        step();
        check("stall_released", 32'(stall), 32'd0);
        drive("add_after_stall", add_h, 11'h021, 1'b1, 1'b0, 1'b0, C_ADD);
        step();

        // rt as destination does not create a hazard.
        drive("lw_t1_b", lw9, 11'h022, 1'b1, 1'b0, 1'b0, C_LW);
        step();
        drive("addi_no_stall", i_ins(6'h08, 3, 9, 16'h0007), 11'h023, 1'b1, 1'b0, 1'b0, C_ADDI);
        #1;
        check("no_stall_rt_dest", 32'(stall), 32'd0);
        step();

        // rt as a store source does.
        drive("lw_t1_c", lw9, 11'h024, 1'b1, 1'b0, 1'b0, C_LW);
        step();
        drive("sw_bubble", i_ins(6'h2B, 3, 9, 16'h0008), 11'h025, 1'b1, 1'b0, 1'b1, 16'h0000);
        #1;
        check("stall_on_sw_rt", 32'(stall), 32'd1);
        step();
        drive("sw_after_stall", i_ins(6'h2B, 3, 9, 16'h0008), 11'h025, 1'b1, 1'b0, 1'b0, C_SW);
        step();

        // A load into r0 never stalls.
        drive("lw_r0", i_ins(6'h23, 16, 0, 16'h0004), 11'h026, 1'b1, 1'b0, 1'b0, C_LW);
        step();
        drive("add_r0", r_ins(0, 0, 12, 6'h20), 11'h027, 1'b1, 1'b0, 1'b0, C_ADD);
        #1;
        check("no_stall_r0", 32'(stall), 32'd0);
        step();

        // Branch targets, including wrap at 11 bits.
        drive("beq_back", i_ins(6'h04, 1, 2, 16'hFFFC), 11'h010, 1'b1, 1'b0, 1'b0, C_BEQ);
        step();
        check("beq_back_dest", 32'(branch_dest), 32'h00C);
        drive("beq_wrap", i_ins(6'h04, 1, 2, 16'h0002), 11'h7FF, 1'b1, 1'b0, 1'b0, C_BEQ);
        step();
        check("beq_wrap_dest", 32'(branch_dest), 32'h001);

        // Flush squashes a valid instruction.
        drive("flush_add", add_h, 11'h040, 1'b1, 1'b1, 1'b1, 16'h0000);
        step();

        // Flush with stall: a single bubble, then the add enters EX directly.
        drive("lw_t1_d", lw9, 11'h041, 1'b1, 1'b0, 1'b0, C_LW);
        step();
        drive("flush_and_stall", add_h, 11'h042, 1'b1, 1'b1, 1'b1, 16'h0000);
        #1;
        check("stall_during_flush", 32'(stall), 32'd1);
        step();
        check("stall_after_flush", 32'(stall), 32'd0);
        drive("add_after_flush_stall", add_h, 11'h042, 1'b1, 1'b0, 1'b0, C_ADD);
        step();

        // Reset mid-run clears ID/EX and the register file.
        drive("lw_before_reset", lw9, 11'h050, 1'b1, 1'b0, 1'b0, C_LW);
        step();
        reset = 1'b1;
        drive("reset_mid_run", add_h, 11'h051, 1'b1, 1'b0, 1'b1, 16'h0000);
        step();
        reset = 1'b0;
        dbg_addr = 5'd5;
        #1;
        check("dbg_r5_after_reset", dbg_data, shadow[5]);
        check("dbg_r5_cleared", dbg_data, 32'd0);

        // WB write to r7 in the same cycle ID reads it.
        wb_write(5'd7, 32'h0000AAAA);
        byp = r_ins(7, 0, 13, 6'h20);
        dbg_addr = 5'd7;
        wb_we = 1'b1; wb_addr = 5'd7; wb_data = 32'h00001234;
        drive("wb_same_cycle", byp, 11'h060, 1'b1, 1'b0, 1'b0, C_ADD);
        #1;
        check("dbg_not_bypassed", dbg_data, 32'h0000AAAA);
        step();
        wb_we = 1'b0;
`ifdef ID_WB_BYPASS_EN
        check("wb_same_cycle_data_a", data_a, 32'h00001234);
`else
        check("wb_same_cycle_data_a", data_a, 32'h0000AAAA);
`endif
        drive("read_after_wb", byp, 11'h061, 1'b1, 1'b0, 1'b0, C_ADD);
        step();
        check("read_after_wb_data_a", data_a, 32'h00001234);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
